interruption_controller: RTL and testbench
==========================================

# interruption_controller

Parametrised interruption controller and preemption timer for the ARMAria control unit. It is the successor to the fixed 4-bit watchdog. It provides a programmable quantum down-counter that runs only while user code executes, edge-detected latching of user and external requests, and fixed-priority encoding. A registered present/acknowledge handshake toward the control unit ensures no interruption is lost or presented twice.

## Interface
- QUANTUM_WIDTH, 16, width of quantum register and down-counter
- DEFAULT_QUANTUM, 16'd1000, quantum value after reset; 0 disables the timer
- NUM_SOURCES, 4, number of external interruption lines
- INTERRUPTION_SIZE, 3, code width; must satisfy 2^INTERRUPTION_SIZE ≥ NUM_SOURCES+3 (elaboration-time check)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- is_Bios, is_kernel, is_input, is_output  in  1 each  privileged/IO execution; any high = "not user cycle"
- is_user_request  in  1  software interruption request (level; rising edge latched)
- irq_in  in  NUM_SOURCES  external lines (level; rising edge latched per line)
- enable  in  1  global presentation enable
- quantum_load  in  1  one-cycle strobe: write quantum_value
- quantum_value  in  QUANTUM_WIDTH  new quantum
- ack  in  1  control unit accepts presented interruption
- irq_valid  out  1  interruption presented
- interruption  out  INTERRUPTION_SIZE  code: 0 none, 1 user, 2 timer, 3+i external line i
- remaining  out  QUANTUM_WIDTH  current down-counter value

## Operation
- Quantum timer:
  - On a user cycle with quantum ≠ 0: if counter==1, set timer pending and reload quantum; else decrement.
  - On a non-user cycle: reload quantum, preserving the original watchdog's reset-on-privilege behaviour.
  - Quantum = 0: counter holds 0 and never expires.
- quantum_load: quantum register and counter both take quantum_value at that edge. This overrides the decrement and expiry of the same cycle.
- Pending vector, NUM_SOURCES+2 bits:
  - Rising edge of is_user_request sets the user bit.
  - Rising edge of irq_in[i] sets bit i.
  - Timer expiry sets the timer bit.
  - Previous-value registers are used for edge detection and reset to 0.
- Priority, combinational over pending: user > external 0 … external N-1 > timer.
- FSM:
  - IDLE → PRESENT: when enable and any pending bit is set. Latch the winning code into interruption and assert irq_valid.
  - PRESENT → IDLE: on ack. Clear the pending bit of the latched code and drive interruption=0 and irq_valid=0.
  - In PRESENT the code is frozen. Higher-priority arrivals wait.
- enable low:
  - In IDLE, nothing is presented; pending bits keep accumulating.
  - In PRESENT, the current presentation holds until ack.
- ack in IDLE is ignored.
- Simultaneous ack and a new event on the same bit: the set wins and the bit stays pending.

## Timing
- Reset values:
  - counter = DEFAULT_QUANTUM, quantum = DEFAULT_QUANTUM
  - pending = 0, edge registers = 0
  - FSM = IDLE, irq_valid = 0, interruption = 0
- Reset asserted mid-presentation aborts it at that edge; no pending state survives.
- Event latency:
  - Input edge sampled at edge k sets pending at edge k.
  - Presentation occurs at edge k+1 (irq_valid high one cycle after the request edge).
- Expiry latency: after a reload with Q, the Q-th consecutive user cycle sets timer pending, and irq_valid rises on the next edge.
- After ack there is at least one IDLE cycle before the next presentation; back-to-back codes are spaced 2 cycles minimum.
- All outputs are registered except remaining, which is the counter register itself.

## Structure
- Shared package interruption_pkg holds:
  - code constants INT_NONE=0, INT_USER=1, INT_TIMER=2, INT_EXT_BASE=3
  - the FSM state enum (IDLE, PRESENT)
- Sub-module quantum_timer owns the quantum register, the down-counter, load and expiry, and outputs expire and remaining.
- Edge detection, pending logic, priority encoder and FSM live in the top module.

## Test plan
- Reset, then hold user cycles with DEFAULT_QUANTUM=1000 → irq_valid at cycle 1001, interruption=2; ack → irq_valid=0 next cycle.
- quantum_load 5, then user cycles with is_kernel pulsed at cycle 3 → counter reloads to 5; expiry 5 user cycles after the pulse, never earlier.
- Raise irq_in[2] and is_user_request in the same cycle → code 1 presented first; after ack and one IDLE cycle, code 5 is presented.
- While presenting code 2, irq_in[0] rises → code stays 2 until ack, then code 3 follows; a level held high on irq_in[0] does not re-trigger after its ack.
- enable=0 with three sources raised → no irq_valid; set enable=1 → presentation in priority order, all three delivered once each.
- quantum_load 0 → no timer interruption over 70000 user cycles; assert reset mid-presentation → irq_valid=0 and remaining=DEFAULT_QUANTUM next cycle.

Source files
------------

// File: rtl/interruption_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interruption_pkg
// Description : Shared interruption codes and presentation FSM states for the
//               ARMAria interruption controller.
// Revision    : 1.0 - initial release
// ============================================================================
package interruption_pkg;

  // Interruption codes seen by the control unit; external line i is
  // INT_EXT_BASE + i.
  localparam int INT_NONE     = 0;
  localparam int INT_USER     = 1;
  localparam int INT_TIMER    = 2;
  localparam int INT_EXT_BASE = 3;

  // Presentation handshake states.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage : interruption_pkg
`default_nettype wire

// File: rtl/interruption_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : interruption_controller_if
// Description : Present/acknowledge handshake between the interruption
//               controller (master) and the control unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface interruption_controller_if #(
  parameter int INTERRUPTION_SIZE = 3
) ();

  logic                         irq_valid;
  logic [INTERRUPTION_SIZE-1:0] interruption;
  logic                         ack;

  // Controller side: presents a code, receives the acceptance.
  modport master (
    output irq_valid,
    output interruption,
    input  ack
  );

  // Control-unit side: observes the code, returns the acceptance.
  modport slave (
    input  irq_valid,
    input  interruption,
    output ack
  );

endinterface : interruption_controller_if
`default_nettype wire

// File: rtl/interruption_controller_quantum_timer.sv
`default_nettype none
// ============================================================================
// Module      : quantum_timer
// Description : Programmable preemption quantum. Counts down only on user
//               cycles, reloads on privileged/IO cycles, flags expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module quantum_timer
  import interruption_pkg::*;
#(
  parameter int                       QUANTUM_WIDTH   = 16,
  parameter logic [QUANTUM_WIDTH-1:0] DEFAULT_QUANTUM = QUANTUM_WIDTH'(1000)
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     user_cycle_i,
  input  wire logic                     load_i,
  input  wire logic [QUANTUM_WIDTH-1:0] load_value_i,
  output logic                          expire_o,
  output logic [QUANTUM_WIDTH-1:0]      remaining_o
);

  logic [QUANTUM_WIDTH-1:0] quantum_q, quantum_d;
  logic [QUANTUM_WIDTH-1:0] count_q,   count_d;

  // Next-state for the quantum and counter; a load beats decrement/expiry.
  always_comb begin
    quantum_d = quantum_q;
    count_d   = count_q;
    expire_o  = 1'b0;
    if (load_i) begin
      quantum_d = load_value_i;
      count_d   = load_value_i;
    end else if (!user_cycle_i) begin
      count_d = quantum_q;
    end else if (quantum_q == '0) begin
      count_d = '0;
    end else if (count_q == QUANTUM_WIDTH'(1)) begin
      count_d  = quantum_q;
      expire_o = 1'b1;
    end else if (count_q == '0) begin
      // Unreachable in normal use; recover by reloading without expiry.
      count_d = quantum_q;
    end else begin
      count_d = count_q - QUANTUM_WIDTH'(1);
    end
  end

  // Quantum and counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      quantum_q <= DEFAULT_QUANTUM;
      count_q   <= DEFAULT_QUANTUM;
    end else begin
      quantum_q <= quantum_d;
      count_q   <= count_d;
    end
  end

  assign remaining_o = count_q;

endmodule : quantum_timer
`default_nettype wire

// File: rtl/interruption_controller.sv
`default_nettype none
// ============================================================================
// Module      : interruption_controller
// Description : Edge-latched user/external/timer requests, fixed-priority
//               selection and registered present/ack handshake toward the
//               control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module interruption_controller
  import interruption_pkg::*;
#(
  parameter int                       QUANTUM_WIDTH     = 16,
  parameter logic [QUANTUM_WIDTH-1:0] DEFAULT_QUANTUM   = QUANTUM_WIDTH'(1000),
  parameter int                       NUM_SOURCES       = 4,
  parameter int                       INTERRUPTION_SIZE = 3
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     is_Bios,
  input  wire logic                     is_kernel,
  input  wire logic                     is_input,
  input  wire logic                     is_output,
  input  wire logic                     is_user_request,
  input  wire logic [NUM_SOURCES-1:0]   irq_in,
  input  wire logic                     enable,
  input  wire logic                     quantum_load,
  input  wire logic [QUANTUM_WIDTH-1:0] quantum_value,
  output logic [QUANTUM_WIDTH-1:0]      remaining,
  interruption_controller_if.master     cu
);

  // Pending layout: [NUM_SOURCES-1:0] external lines, then user, then timer.
  localparam int PEND_W    = NUM_SOURCES + 2;
  localparam int BIT_USER  = NUM_SOURCES;
  localparam int BIT_TIMER = NUM_SOURCES + 1;

  if ((1 << INTERRUPTION_SIZE) < (NUM_SOURCES + 3)) begin : g_size_check
    $error("INTERRUPTION_SIZE too small to encode all interruption codes");
  end

  logic                         user_cycle;
  logic                         expire;
  logic                         user_req_prev_q;
  logic [NUM_SOURCES-1:0]       irq_prev_q;
  logic [PEND_W-1:0]            set_vec;
  logic [PEND_W-1:0]            pending_q, pending_d;
  logic                         ack_accept;
  logic [INTERRUPTION_SIZE-1:0] win_code;
  logic [PEND_W-1:0]            win_mask;
  state_e                       state_q;
  logic                         irq_valid_q;
  logic [INTERRUPTION_SIZE-1:0] code_q;
  logic [PEND_W-1:0]            mask_q;

  assign user_cycle = ~(is_Bios | is_kernel | is_input | is_output);

  quantum_timer #(
    .QUANTUM_WIDTH   (QUANTUM_WIDTH),
    .DEFAULT_QUANTUM (DEFAULT_QUANTUM)
  ) u_quantum_timer (
    .clock        (clock),
    .reset        (reset),
    .user_cycle_i (user_cycle),
    .load_i       (quantum_load),
    .load_value_i (quantum_value),
    .expire_o     (expire),
    .remaining_o  (remaining)
  );

  // Rising-edge events this cycle and pending update; a new set beats the
  // clear from an acknowledge on the same bit.
  always_comb begin
    set_vec                  = '0;
    set_vec[NUM_SOURCES-1:0] = irq_in & ~irq_prev_q;
    set_vec[BIT_USER]        = is_user_request & ~user_req_prev_q;
    set_vec[BIT_TIMER]       = expire;
    ack_accept               = (state_q == PRESENT) && cu.ack;
    pending_d                = (pending_q & ~(ack_accept ? mask_q : '0)) | set_vec;
  end

  // Fixed priority: user > external 0..N-1 > timer (later assignments win).
  always_comb begin
    win_code = INTERRUPTION_SIZE'(INT_NONE);
    win_mask = '0;
    if (pending_q[BIT_TIMER]) begin
      win_code            = INTERRUPTION_SIZE'(INT_TIMER);
      win_mask[BIT_TIMER] = 1'b1;
    end
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        win_code    = INTERRUPTION_SIZE'(INT_EXT_BASE + i);
        win_mask    = '0;
        win_mask[i] = 1'b1;
      end
    end
    if (pending_q[BIT_USER]) begin
      win_code           = INTERRUPTION_SIZE'(INT_USER);
      win_mask           = '0;
      win_mask[BIT_USER] = 1'b1;
    end
  end

  // Edge-detect history and pending vector.
  always_ff @(posedge clock) begin
    if (!reset) begin
      user_req_prev_q <= 1'b0;
      irq_prev_q      <= '0;
      pending_q       <= '0;
    end else begin
      user_req_prev_q <= is_user_request;
      irq_prev_q      <= irq_in;
      pending_q       <= pending_d;
    end
  end

  // Presentation FSM: latch the winner, hold it frozen until acknowledged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      code_q      <= INTERRUPTION_SIZE'(INT_NONE);
      mask_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && (|pending_q)) begin
            state_q     <= PRESENT;
            irq_valid_q <= 1'b1;
            code_q      <= win_code;
            mask_q      <= win_mask;
          end
        end
        PRESENT: begin
          if (cu.ack) begin
            state_q     <= IDLE;
            irq_valid_q <= 1'b0;
            code_q      <= INTERRUPTION_SIZE'(INT_NONE);
            mask_q      <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          irq_valid_q <= 1'b0;
          code_q      <= INTERRUPTION_SIZE'(INT_NONE);
          mask_q      <= '0;
        end
      endcase
    end
  end

  assign cu.irq_valid    = irq_valid_q;
  assign cu.interruption = code_q;

endmodule : interruption_controller
`default_nettype wire

// File: tb/tb_interruption_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interruption_controller
// Description : Self-checking bench for interruption_controller: directed
//               scenarios with literal expectations plus randomized traffic,
//               every cycle compared to a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interruption_controller;

  localparam int NS = 4;
  localparam int QW = 16;
  localparam int IS = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b0;
  logic          is_Bios = 1'b0, is_kernel = 1'b0, is_input = 1'b0, is_output = 1'b0;
  logic          is_user_request = 1'b0;
  logic [NS-1:0] irq_in = '0;
  logic          enable = 1'b1;
  logic          quantum_load = 1'b0;
  logic [QW-1:0] quantum_value = '0;
  logic          ack = 1'b0;
  logic [QW-1:0] remaining;

  interruption_controller_if #(.INTERRUPTION_SIZE(IS)) cu ();
  assign cu.ack = ack;

  interruption_controller #(
    .QUANTUM_WIDTH     (QW),
    .DEFAULT_QUANTUM   (16'd1000),
    .NUM_SOURCES       (NS),
    .INTERRUPTION_SIZE (IS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .is_Bios         (is_Bios),
    .is_kernel       (is_kernel),
    .is_input        (is_input),
    .is_output       (is_output),
    .is_user_request (is_user_request),
    .irq_in          (irq_in),
    .enable          (enable),
    .quantum_load    (quantum_load),
    .quantum_value   (quantum_value),
    .remaining       (remaining),
    .cu              (cu.master)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: quantum Q, consecutive user cycles since last reload,
  // pending flags indexed by interruption code, and the current presentation.
  int  m_q = 1000;
  int  m_e = 0;
  bit  m_pend [0:7];
  bit  m_valid = 0;
  int  m_code = 0;
  bit  m_prev_req = 0;
  bit  [NS-1:0] m_prev_irq = '0;
  int  prio [0:NS+1];

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_step();
    bit user;
    bit exp;
    bit found;
    if (!reset) begin
      m_q = 1000; m_e = 0; m_valid = 0; m_code = 0;
      m_prev_req = 0; m_prev_irq = '0;
      for (int c = 0; c < 8; c++) m_pend[c] = 0;
      return;
    end
    user = !(is_Bios || is_kernel || is_input || is_output);
    exp  = 0;
    if (quantum_load) begin
      m_q = int'(quantum_value);
      m_e = 0;
    end else if (!user) begin
      m_e = 0;
    end else if (m_q != 0) begin
      m_e++;
      if (m_e == m_q) begin
        exp = 1;
        m_e = 0;
      end
    end
    if (m_valid) begin
      if (ack) begin
        m_pend[m_code] = 0;
        m_valid = 0;
        m_code  = 0;
      end
    end else if (enable) begin
      found = 0;
      for (int k = 0; k < NS + 2; k++) begin
        if (!found && m_pend[prio[k]]) begin
          found   = 1;
          m_valid = 1;
          m_code  = prio[k];
        end
      end
    end
    if (is_user_request && !m_prev_req) m_pend[1] = 1;
    for (int i = 0; i < NS; i++)
      if (irq_in[i] && !m_prev_irq[i]) m_pend[3 + i] = 1;
    if (exp) m_pend[2] = 1;
    m_prev_req = is_user_request;
    m_prev_irq = irq_in;
  endfunction

  // One clock: predict, let the edge happen, compare just after it.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("irq_valid", int'(cu.irq_valid), int'(m_valid));
    chk("interruption", int'(cu.interruption), m_code);
    chk("remaining", int'(remaining), (m_q == 0) ? 0 : (m_q - m_e));
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!cu.irq_valid && n < budget) begin
      tick();
      n++;
    end
    if (!cu.irq_valid) chk("wait_valid_timeout", int'(cu.irq_valid), 1);
  endtask

  task automatic ack_once();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    int n;
    int vcount;
    int got [0:2];
    prio[0] = 1;
    for (int i = 0; i < NS; i++) prio[1 + i] = 3 + i;
    prio[NS + 1] = 2;
    for (int c = 0; c < 8; c++) m_pend[c] = 0;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    chk("rst_irq_valid", int'(cu.irq_valid), 0);
    chk("rst_code", int'(cu.interruption), 0);
    chk("rst_remaining", int'(remaining), 1000);

    // Default quantum expiry under continuous user cycles
    reset = 1'b1;
    wait_valid(1100, n);
    chk("default_expiry_cycle", n, 1001);
    chk("default_expiry_code", int'(cu.interruption), 2);
    ack_once();
    chk("ack_drops_valid", int'(cu.irq_valid), 0);

    // Load 5, privileged pulse on the third cycle restarts the quantum
    quantum_load = 1'b1; quantum_value = 16'd5;
    tick();
    quantum_load = 1'b0;
    chk("load_remaining", int'(remaining), 5);
    tick();
    tick();
    is_kernel = 1'b1;
    tick();
    chk("kernel_reload", int'(remaining), 5);
    is_kernel = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("no_early_expiry", int'(cu.irq_valid), 0);
    end
    tick();
    chk("q5_expiry_valid", int'(cu.irq_valid), 1);
    chk("q5_expiry_code", int'(cu.interruption), 2);
    is_kernel = 1'b1;
    ack_once();

    // Simultaneous user request and irq_in[2]
    is_user_request = 1'b1; irq_in[2] = 1'b1;
    tick();
    chk("simul_latency", int'(cu.irq_valid), 0);
    tick();
    chk("simul_first_code", int'(cu.interruption), 1);
    ack_once();
    chk("simul_idle_gap", int'(cu.irq_valid), 0);
    tick();
    chk("simul_second_code", int'(cu.interruption), 5);
    ack_once();
    is_user_request = 1'b0; irq_in = '0;
    tick();

    // Code frozen during presentation; held level does not re-trigger
    is_kernel = 1'b0;
    quantum_load = 1'b1; quantum_value = 16'd3;
    tick();
    quantum_load = 1'b0;
    wait_valid(10, n);
    chk("freeze_timer_code", int'(cu.interruption), 2);
    is_kernel = 1'b1;
    irq_in[0] = 1'b1;
    tick();
    tick();
    chk("frozen_code", int'(cu.interruption), 2);
    ack_once();
    tick();
    chk("follow_code", int'(cu.interruption), 3);
    ack_once();
    vcount = 0;
    repeat (5) begin
      tick();
      vcount += int'(cu.irq_valid);
    end
    chk("level_no_retrigger", vcount, 0);
    irq_in = '0;
    tick();

    // Enable low accumulates; enable high delivers in priority order
    enable = 1'b0;
    irq_in[1] = 1'b1; irq_in[3] = 1'b1; is_user_request = 1'b1;
    vcount = 0;
    repeat (4) begin
      tick();
      vcount += int'(cu.irq_valid);
    end
    chk("disabled_no_valid", vcount, 0);
    enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_valid(5, n);
      got[p] = int'(cu.interruption);
      ack_once();
    end
    chk("order_0", got[0], 1);
    chk("order_1", got[1], 4);
    chk("order_2", got[2], 6);
    vcount = 0;
    repeat (3) begin
      tick();
      vcount += int'(cu.irq_valid);
    end
    chk("delivered_once", vcount, 0);
    irq_in = '0; is_user_request = 1'b0;

    // Quantum 0 never expires
    is_kernel = 1'b0;
    quantum_load = 1'b1; quantum_value = '0;
    tick();
    quantum_load = 1'b0;
    vcount = 0;
    repeat (70000) begin
      tick();
      vcount += int'(cu.irq_valid);
    end
    chk("q0_no_timer", vcount, 0);

    // Reset in the middle of a presentation
    irq_in[0] = 1'b1;
    tick();
    tick();
    chk("pre_reset_valid", int'(cu.irq_valid), 1);
    reset = 1'b0;
    irq_in = '0;
    tick();
    chk("mid_reset_valid", int'(cu.irq_valid), 0);
    chk("mid_reset_remaining", int'(remaining), 1000);
    reset = 1'b1;

    // Randomized traffic against the model
    quantum_load = 1'b1; quantum_value = 16'd4;
    tick();
    quantum_load = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      is_Bios   = ($urandom_range(0, 15) == 0);
      is_kernel = ($urandom_range(0, 15) == 0);
      is_input  = ($urandom_range(0, 31) == 0);
      is_output = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) is_user_request = ~is_user_request;
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
      enable        = ($urandom_range(0, 7) != 0);
      ack           = ($urandom_range(0, 2) == 0);
      quantum_load  = ($urandom_range(0, 49) == 0);
      quantum_value = QW'($urandom_range(0, 6));
      reset         = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_interruption_controller
`default_nettype wire
